blk_a3925e: RTL and testbench



---
 rtl/blk_a3925e.sv | 95 +++++++++
 tb/tb_blk_a3925e.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blk_a3925e.sv
// Write-side control of the dual-clock FIFO: input handshake, memory write port, Gray write pointer, full and level.
// Optional almost_full output is enabled by defining LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN.
module blk_a3925e #(
    parameter int ADDRESS_WIDTH = 4
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
    , parameter int ALMOST_FULL = 2**ADDRESS_WIDTH - 1
`endif
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     tvalid,
    output logic                     tready,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [ADDRESS_WIDTH:0]   write_pointer,
    input  logic [ADDRESS_WIDTH:0]   read_pointer_synced,
    output logic                     full,
    output logic [ADDRESS_WIDTH:0]   level
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
    , output logic                   almost_full
`endif
);

    localparam int PW = ADDRESS_WIDTH + 1;
    // Full when the Gray pointers differ only in their two top bits (both bits when ADDRESS_WIDTH is 1).
    localparam logic [PW-1:0] FULL_MASK = PW'(3 << (ADDRESS_WIDTH - 1));

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_write_pointer;
    logic          r_full;
    logic          r_tready;
    logic [PW-1:0] r_level;

    logic          w_accept;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin;
    logic          w_full_next;
    logic [PW-1:0] w_level_next;

    assign w_accept     = tvalid && r_tready;
    assign w_wbin_next  = r_wbin + {{ADDRESS_WIDTH{1'b0}}, w_accept};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
    assign w_full_next  = (w_wgray_next == (read_pointer_synced ^ FULL_MASK));
    assign w_level_next = w_wbin_next - w_rbin;

    // NOTE: the default assignment ahead of the loop keeps every bit driven on every path, so no latch is inferred.
    always_comb begin
        w_rbin = '0;
        for (int i = 0; i < PW; i++) begin
            w_rbin[i] = ^(read_pointer_synced >> i);
        end
    end

    // NOTE: non-blocking assignments throughout so every register samples the pre-edge values of its peers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wbin          <= '0;
            r_write_pointer <= '0;
            r_full          <= 1'b0;
            r_tready        <= 1'b0;
            r_level         <= '0;
        end else begin
            r_wbin          <= w_wbin_next;
            r_write_pointer <= w_wgray_next;
            r_full          <= w_full_next;
            r_tready        <= ~w_full_next;
            r_level         <= w_level_next;
        end
    end

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
    localparam logic [PW-1:0] AF_THRESHOLD = PW'(ALMOST_FULL);

    logic r_almost_full;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_almost_full <= 1'b0;
        end else begin
            r_almost_full <= (w_level_next >= AF_THRESHOLD);
        end
    end

    assign almost_full = r_almost_full;
`endif

    assign tready        = r_tready;
    assign write_enable  = w_accept;
    assign write_address = r_wbin[ADDRESS_WIDTH-1:0];
    assign write_pointer = r_write_pointer;
    assign full          = r_full;
    assign level         = r_level;

endmodule

// File: tb/tb_blk_a3925e.sv
// Self-checking bench for blk_a3925e: write/read counts model drives expectations for pointer, address, level and full.
// Exercises almost_full too when LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN is defined.
module tb_blk_a3925e;

    localparam int AW    = 4;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;
    localparam int PMOD  = 1 << PW;
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
    localparam int AF    = 12;
`endif

    logic          aclk = 1'b0;
    logic          areset;
    logic          tvalid;
    logic          tready;
    logic          write_enable;
    logic [AW-1:0] write_address;
    logic [PW-1:0] write_pointer;
    logic [PW-1:0] read_pointer_synced;
    logic          full;
    logic [PW-1:0] level;
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
    logic          almost_full;
`endif

    always #5 aclk = ~aclk;

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
    blk_a3925e #(.ADDRESS_WIDTH(AW), .ALMOST_FULL(AF)) dut (
`else
    blk_a3925e #(.ADDRESS_WIDTH(AW)) dut (
`endif
        .aclk                (aclk),
        .areset              (areset),
        .tvalid              (tvalid),
        .tready              (tready),
        .write_enable        (write_enable),
        .write_address       (write_address),
        .write_pointer       (write_pointer),
        .read_pointer_synced (read_pointer_synced),
        .full                (full),
        .level               (level)
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
        , .almost_full       (almost_full)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: counts of words written and read, plus the handshake readiness seen by the producer.
    int m_wcount = 0;
    int m_rcount = 0;
    bit m_tready = 1'b0;
    int m_level  = 0;
    bit m_full   = 1'b0;

    logic          obs_we;
    logic [AW-1:0] obs_waddr;
    bit            exp_we;
    int            exp_waddr;

    function automatic logic [PW-1:0] gray(input int n);
        int m;
        m = n % PMOD;
        return PW'(m ^ (m >> 1));
    endfunction

    // One clock: drive inputs, sample combinational outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle(input bit rst, input bit tv, input int rc);
        areset              = rst;
        tvalid              = tv;
        m_rcount            = rc;
        read_pointer_synced = gray(rc);
        @(negedge aclk);
        obs_we    = write_enable;
        obs_waddr = write_address;
        exp_we    = tv && m_tready;
        exp_waddr = m_wcount % DEPTH;
        @(posedge aclk);
        if (rst) begin
            m_wcount = 0;
            m_tready = 1'b0;
            m_level  = 0;
            m_full   = 1'b0;
        end else begin
            if (exp_we) m_wcount++;
            m_level  = ((m_wcount - m_rcount) % PMOD + PMOD) % PMOD;
            m_full   = (m_level == DEPTH);
            m_tready = !m_full;
        end
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 0);
            if (i > 0) begin
                if (obs_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", obs_we); end
                n_checks++;
            end
            if ({tready, full, level, write_pointer} !== '0) begin
                n_fail++;
                $display("FAIL reset_state got tready=%b full=%b level=%0d wp=%b exp all 0", tready, full, level, write_pointer);
            end
            n_checks++;
        end
        cycle(1'b0, 1'b1, 0);
        if (obs_we !== 1'b0) begin n_fail++; $display("FAIL release_we got=%b exp=0", obs_we); end
        n_checks++;
        if (tready !== 1'b1) begin n_fail++; $display("FAIL release_tready got=%b exp=1", tready); end
        n_checks++;
        cycle(1'b0, 1'b0, 0);
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, 1'b1, 0);
            if (obs_we !== 1'b1 || obs_waddr !== AW'(i)) begin
                n_fail++;
                $display("FAIL fill_write[%0d] got we=%b addr=%0d exp we=1 addr=%0d", i, obs_we, obs_waddr, i);
            end
            n_checks++;
            if (write_pointer !== gray(i + 1) || level !== PW'(i + 1)) begin
                n_fail++;
                $display("FAIL fill_ptr[%0d] got wp=%b level=%0d exp wp=%b level=%0d", i, write_pointer, level, gray(i + 1), i + 1);
            end
            n_checks++;
        end
        if (full !== 1'b1 || tready !== 1'b0 || level !== 5'd16 || write_pointer !== 5'b11000) begin
            n_fail++;
            $display("FAIL fill_full got full=%b tready=%b level=%0d wp=%b exp 1 0 16 11000", full, tready, level, write_pointer);
        end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 0);
            if (obs_we !== 1'b0 || write_pointer !== 5'b11000) begin
                n_fail++;
                $display("FAIL full_hold got we=%b wp=%b exp we=0 wp=11000", obs_we, write_pointer);
            end
            n_checks++;
        end
    endtask

    task automatic test_release();
        cycle(1'b0, 1'b0, 1);
        if (full !== 1'b0 || tready !== 1'b1 || level !== 5'd15) begin
            n_fail++;
            $display("FAIL release_state got full=%b tready=%b level=%0d exp 0 1 15", full, tready, level);
        end
        n_checks++;
        cycle(1'b0, 1'b1, 1);
        if (obs_we !== 1'b1 || obs_waddr !== 4'd0) begin
            n_fail++;
            $display("FAIL release_write got we=%b addr=%0d exp we=1 addr=0", obs_we, obs_waddr);
        end
        n_checks++;
        if (write_pointer !== 5'b11001 || full !== 1'b1 || tready !== 1'b0) begin
            n_fail++;
            $display("FAIL refill got wp=%b full=%b tready=%b exp 11001 1 0", write_pointer, full, tready);
        end
        n_checks++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 1);
        if (obs_we !== 1'b1 || level !== 5'd8 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL simultaneous got we=%b level=%0d full=%b exp we=1 level=8 full=0", obs_we, level, full);
        end
        n_checks++;
    endtask

    task automatic test_random();
        int rc;
        do_reset();
        rc = 0;
        for (int i = 0; i < 400; i++) begin
            // Slow reader first to reach full, then a fast reader to drain.
            if (rc < m_wcount && $urandom_range(0, 3) < ((i < 200) ? 1 : 3)) rc++;
            cycle(1'b0, 1'($urandom_range(0, 1)), rc);
            if (obs_we !== exp_we || (exp_we && obs_waddr !== AW'(exp_waddr))) begin
                n_fail++;
                $display("FAIL rand_write[%0d] got we=%b addr=%0d exp we=%b addr=%0d", i, obs_we, obs_waddr, exp_we, exp_waddr);
            end
            n_checks++;
            if (write_pointer !== gray(m_wcount) || level !== PW'(m_level) || full !== m_full || tready !== m_tready) begin
                n_fail++;
                $display("FAIL rand_state[%0d] got wp=%b level=%0d full=%b tready=%b exp wp=%b level=%0d full=%b tready=%b",
                         i, write_pointer, level, full, tready, gray(m_wcount), m_level, m_full, m_tready);
            end
            n_checks++;
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
            if (almost_full !== (m_level >= AF)) begin
                n_fail++;
                $display("FAIL rand_af[%0d] got=%b level=%0d", i, almost_full, m_level);
            end
            n_checks++;
`endif
        end
    endtask

    task automatic test_wrap();
        bit seen_top;
        bit seen_zero;
        seen_top  = 1'b0;
        seen_zero = 1'b0;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 0);
        for (int i = 0; i < 37; i++) begin
            cycle(1'b0, 1'b1, m_wcount + 1 - 3);
            if (level !== 5'd3 || full !== 1'b0 || write_pointer !== gray(m_wcount)) begin
                n_fail++;
                $display("FAIL wrap[%0d] got level=%0d full=%b wp=%b exp level=3 full=0 wp=%b", i, level, full, write_pointer, gray(m_wcount));
            end
            n_checks++;
            if (write_pointer === 5'b10000) seen_top = 1'b1;
            if (seen_top && write_pointer === 5'b00000) seen_zero = 1'b1;
        end
        if (!(seen_top && seen_zero)) begin
            n_fail++;
            $display("FAIL wrap_seen got top=%b zero=%b exp both 1", seen_top, seen_zero);
        end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 0);
        if (level !== 5'd10) begin n_fail++; $display("FAIL mid_level got=%0d exp=10", level); end
        n_checks++;
        cycle(1'b1, 1'b1, 0);
        if (level !== '0 || write_pointer !== '0 || write_enable !== 1'b0 || tready !== 1'b0 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got level=%0d wp=%b we=%b tready=%b full=%b exp all 0",
                     level, write_pointer, write_enable, tready, full);
        end
        n_checks++;
        cycle(1'b0, 1'b0, 0);
    endtask

`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
    task automatic test_almost_full();
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cycle(1'b0, 1'b1, 0);
            if (almost_full !== (i + 1 >= AF)) begin
                n_fail++;
                $display("FAIL af[%0d] got=%b level=%0d exp=%b", i, almost_full, level, (i + 1 >= AF));
            end
            n_checks++;
        end
    endtask
`endif

    initial begin
        areset              = 1'b1;
        tvalid              = 1'b0;
        read_pointer_synced = '0;
        @(posedge aclk);
        #1;
        test_reset();
        test_fill();
        test_release();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_random();
`ifdef LOGIC_CLOCK_DOMAIN_CROSSING_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
